// File: rtl/adder_arb_pkg.sv
// Shared types and default sizing for the two-requester pipelined adder.
package adder_arb_pkg;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } tag_e;

    localparam int DEF_N   = 8;
    localparam int DEF_LAT = 2;

endpackage

// File: rtl/adder_arb_pipe.sv
// LAT-stage registered add path; the sum is formed at entry and then shifted
// along with its valid bit and requester tag.
module adder_arb_pipe
    import adder_arb_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int LAT = DEF_LAT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_valid,
    input  tag_e         i_tag,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic         o_valid,
    output tag_e         o_tag,
    output logic [N:0]   o_res
);

    logic [LAT-1:0] r_valid;
    tag_e           r_tag [LAT];
    logic [N:0]     r_res [LAT];
    logic [N:0]     w_res;

    // Widened by one bit so the carry-out lands in the MSB.
    assign w_res = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_cin};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_tag[i] <= REQ0;
                r_res[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_tag[0]   <= i_tag;
            r_res[0]   <= w_res;
            for (int i = 1; i < LAT; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_tag[i]   <= r_tag[i-1];
                r_res[i]   <= r_res[i-1];
            end
        end
    end

    assign o_valid = r_valid[LAT-1];
    assign o_tag   = r_tag[LAT-1];
    assign o_res   = r_res[LAT-1];

endmodule

// File: rtl/adder_arbiter.sv
// Two-requester arbiter in front of a shared pipelined adder; results are steered
// back by tag. Define ADDER_ARBITER_RR_EN for round-robin ties, else req0 wins.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int LAT = DEF_LAT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    input  logic                     req1_valid,
    output logic                     req0_ready,
    output logic                     req1_ready,
    input  logic [N-1:0]             req0_a,
    input  logic [N-1:0]             req0_b,
    input  logic [N-1:0]             req1_a,
    input  logic [N-1:0]             req1_b,
    input  logic                     req0_cin,
    input  logic                     req1_cin,
    output logic                     rsp0_valid,
    output logic                     rsp1_valid,
    output logic [N-1:0]             rsp0_sum,
    output logic [N-1:0]             rsp1_sum,
    output logic                     rsp0_cout,
    output logic                     rsp1_cout,
    output logic [$clog2(LAT+1)-1:0] inflight
);

    localparam int IW = $clog2(LAT+1);

    logic          w_pick1;
    logic          w_xfer;
    tag_e          w_tag;
    logic [N-1:0]  w_a;
    logic [N-1:0]  w_b;
    logic          w_cin;
    logic          w_pv;
    tag_e          w_ptag;
    logic [N:0]    w_pres;
    logic [IW-1:0] r_inflight;

`ifdef ADDER_ARBITER_RR_EN
    tag_e r_last_grant;

    // Reset to REQ1 so the first tie after reset goes to req0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= REQ1;
        end else if (w_xfer) begin
            r_last_grant <= w_tag;
        end
    end

    assign w_pick1 = req1_valid && (!req0_valid || r_last_grant == REQ0);
`else
    assign w_pick1 = req1_valid && !req0_valid;
`endif

    assign req1_ready = !reset && w_pick1;
    assign req0_ready = !reset && req0_valid && !w_pick1;
    assign w_xfer     = req0_ready || req1_ready;
    assign w_tag      = req1_ready ? REQ1 : REQ0;
    assign w_a        = req1_ready ? req1_a   : req0_a;
    assign w_b        = req1_ready ? req1_b   : req0_b;
    assign w_cin      = req1_ready ? req1_cin : req0_cin;

    adder_arb_pipe #(
        .N   (N),
        .LAT (LAT)
    ) u_pipe (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_xfer),
        .i_tag   (w_tag),
        .i_a     (w_a),
        .i_b     (w_b),
        .i_cin   (w_cin),
        .o_valid (w_pv),
        .o_tag   (w_ptag),
        .o_res   (w_pres)
    );

    assign rsp0_valid             = !reset && w_pv && (w_ptag == REQ0);
    assign rsp1_valid             = !reset && w_pv && (w_ptag == REQ1);
    assign {rsp0_cout, rsp0_sum}  = rsp0_valid ? w_pres : '0;
    assign {rsp1_cout, rsp1_sum}  = rsp1_valid ? w_pres : '0;

    // A transfer and a retirement in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight <= '0;
        end else if (w_xfer && !w_pv && r_inflight != IW'(LAT)) begin
            r_inflight <= r_inflight + 1'b1;
        end else if (!w_xfer && w_pv && r_inflight != '0) begin
            r_inflight <= r_inflight - 1'b1;
        end
    end

    assign inflight = reset ? '0 : r_inflight;

endmodule

// File: tb/tb_adder_arbiter.sv
// Table-driven bench for adder_arbiter (N=8, LAT=2), one table row per clock cycle,
// plus hand-written reset sequences.
module tb_adder_arbiter;

    logic       clk;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       req0_cin, req1_cin;
    logic       rsp0_valid, rsp1_valid;
    logic [7:0] rsp0_sum, rsp1_sum;
    logic       rsp0_cout, rsp1_cout;
    logic [1:0] inflight;

    int n_checks;
    int n_errors;

    adder_arbiter #(.N(8), .LAT(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req0_cin   (req0_cin),
        .req1_cin   (req1_cin),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp0_sum   (rsp0_sum),
        .rsp1_sum   (rsp1_sum),
        .rsp0_cout  (rsp0_cout),
        .rsp1_cout  (rsp1_cout),
        .inflight   (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v0, v1;
        logic [7:0] a0, b0;
        logic       c0;
        logic [7:0] a1, b1;
        logic       c1;
        logic       r0, r1;
        logic       rv0;
        logic [7:0] s0;
        logic       co0;
        logic       rv1;
        logic [7:0] s1;
        logic       co1;
        logic [1:0] inf;
    } vec_t;

    vec_t vecs[$];

    // ch: 0 = no response, 1 = response on port 0, 2 = response on port 1.
    function automatic vec_t mk(input logic v0, input logic v1,
                                input int a0, input int b0, input int c0,
                                input int a1, input int b1, input int c1,
                                input logic r0, input logic r1,
                                input int ch, input int sum, input int cout, input int inf);
        vec_t v;
        v.v0 = v0; v.v1 = v1;
        v.a0 = 8'(a0); v.b0 = 8'(b0); v.c0 = 1'(c0);
        v.a1 = 8'(a1); v.b1 = 8'(b1); v.c1 = 1'(c1);
        v.r0 = r0; v.r1 = r1;
        v.rv0 = (ch == 1); v.s0 = (ch == 1) ? 8'(sum) : 8'd0; v.co0 = (ch == 1) ? 1'(cout) : 1'b0;
        v.rv1 = (ch == 2); v.s1 = (ch == 2) ? 8'(sum) : 8'd0; v.co1 = (ch == 2) ? 1'(cout) : 1'b0;
        v.inf = 2'(inf);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v0, input logic v1,
                         input logic [7:0] a0, input logic [7:0] b0, input logic c0,
                         input logic [7:0] a1, input logic [7:0] b1, input logic c1);
        req0_valid = v0; req1_valid = v1;
        req0_a = a0; req0_b = b0; req0_cin = c0;
        req1_a = a1; req1_b = b1; req1_cin = c1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0);
    endtask

    task automatic chk_outs(input string tag, input logic r0, input logic r1,
                            input logic rv0, input logic [7:0] s0, input logic co0,
                            input logic rv1, input logic [7:0] s1, input logic co1,
                            input logic [1:0] inf);
        chk({tag, " req0_ready"}, int'(req0_ready), int'(r0));
        chk({tag, " req1_ready"}, int'(req1_ready), int'(r1));
        chk({tag, " rsp0_valid"}, int'(rsp0_valid), int'(rv0));
        chk({tag, " rsp0_sum"},   int'(rsp0_sum),   int'(s0));
        chk({tag, " rsp0_cout"},  int'(rsp0_cout),  int'(co0));
        chk({tag, " rsp1_valid"}, int'(rsp1_valid), int'(rv1));
        chk({tag, " rsp1_sum"},   int'(rsp1_sum),   int'(s1));
        chk({tag, " rsp1_cout"},  int'(rsp1_cout),  int'(co1));
        chk({tag, " inflight"},   int'(inflight),   int'(inf));
    endtask

    // Advance to just after the next rising edge so inputs change away from it.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic rr;
        n_checks = 0;
        n_errors = 0;
`ifdef ADDER_ARBITER_RR_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif

        // Contention first so the round-robin starts from its reset state.
        vecs.push_back(mk(1, 1, 100, 55, 0, 127, 1, 1, 1'b1, 1'b0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 100, 55, 0, 127, 1, 1, !rr, rr, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 100, 55, 0, 127, 1, 1, 1'b1, 1'b0, 1, 155, 0, 2));
        vecs.push_back(mk(1, 1, 100, 55, 0, 127, 1, 1, !rr, rr, rr ? 2 : 1, rr ? 129 : 155, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1, 155, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, rr ? 2 : 1, rr ? 129 : 155, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 0));
        // Single request, then carry-out cases on both ports.
        vecs.push_back(mk(1, 0, 10, 20, 0, 0, 0, 0, 1'b1, 1'b0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 255, 1, 1, 1'b0, 1'b1, 1, 30, 0, 1));
        vecs.push_back(mk(1, 0, 128, 128, 0, 0, 0, 0, 1'b1, 1'b0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 2, 1, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 0));
        // Back-to-back on req0: a = 1..5, b = 10.
        vecs.push_back(mk(1, 0, 1, 10, 0, 0, 0, 0, 1'b1, 1'b0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 2, 10, 0, 0, 0, 0, 1'b1, 1'b0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 3, 10, 0, 0, 0, 0, 1'b1, 1'b0, 1, 11, 0, 2));
        vecs.push_back(mk(1, 0, 4, 10, 0, 0, 0, 0, 1'b1, 1'b0, 1, 12, 0, 2));
        vecs.push_back(mk(1, 0, 5, 10, 0, 0, 0, 0, 1'b1, 1'b0, 1, 13, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1, 14, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1, 15, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 0));

        // Reset with both requesters asserting: nothing may be granted.
        reset = 1'b1;
        drive(1'b1, 1'b1, 8'd3, 8'd4, 1'b0, 8'd5, 8'd6, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk_outs("in_reset", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 2'd0);
        next_cycle();
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].v0, vecs[i].v1, vecs[i].a0, vecs[i].b0, vecs[i].c0,
                  vecs[i].a1, vecs[i].b1, vecs[i].c1);
            @(negedge clk);
            chk_outs($sformatf("row%0d", i), vecs[i].r0, vecs[i].r1,
                     vecs[i].rv0, vecs[i].s0, vecs[i].co0,
                     vecs[i].rv1, vecs[i].s1, vecs[i].co1, vecs[i].inf);
            next_cycle();
        end

        // Reset mid-flight: two ops issued, then a single reset cycle.
        drive(1'b1, 1'b0, 8'd1, 8'd1, 1'b0, 8'd0, 8'd0, 1'b0);
        next_cycle();
        drive(1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 8'd2, 8'd2, 1'b0);
        @(negedge clk);
        chk("mid issue2 req1_ready", int'(req1_ready), 1);
        next_cycle();
        idle();
        reset = 1'b1;
        @(negedge clk);
        chk_outs("mid_reset", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 2'd0);
        next_cycle();
        reset = 1'b0;
        // First cycle after reset: tie must go to req0 and be accepted.
        drive(1'b1, 1'b1, 8'd40, 8'd2, 1'b1, 8'd9, 8'd9, 1'b0);
        @(negedge clk);
        chk_outs("post_rst0", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 2'd0);
        next_cycle();
        idle();
        @(negedge clk);
        chk_outs("post_rst1", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1);
        next_cycle();
        @(negedge clk);
        chk_outs("post_rst2", 1'b0, 1'b0, 1'b1, 8'd43, 1'b0, 1'b0, 8'd0, 1'b0, 2'd1);
        next_cycle();
        repeat (2) begin
            @(negedge clk);
            chk_outs("post_rst_q", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 2'd0);
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
